gray_stream_ctrl: RTL and testbench

Streaming controller that sequences the 24-bit RGB-to-grayscale datapath over one full BMP frame. It takes the BMP pixel array as a byte stream in file order (B, G, R per pixel, each row zero-padded to a 4-byte multiple), assembles 24-bit pixels and drops row padding. It applies the 77/150/29 luma weighting and emits one 8-bit gray sample per pixel on a valid/ready output with row and frame markers. It sits between the DMA/byte source that has already stripped the BMP header and the gray-image sink.

---
 rtl/gray_stream_ctrl.sv | 139 +++++++++++++
 tb/tb_gray_stream_ctrl.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/gray_stream_ctrl.sv
// gray_stream_ctrl: sequences a BMP pixel byte stream into an 8-bit gray sample stream for one frame
// Ports:
//    clk, rst_n             clock, asynchronous active-low reset
//    start                  pulse in IDLE to begin a frame
//    s_data/s_valid/s_ready byte input, B,G,R per pixel, rows zero-padded to 4-byte multiples
//    m_data/m_valid/m_ready gray sample output; m_last marks the last pixel of a row
//    busy                   high outside IDLE
//    frame_done             one-cycle pulse once the final sample has been delivered
module gray_stream_ctrl #(
   parameter int WIDTH  = 640,
   parameter int HEIGHT = 480
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       start,
   input  logic [7:0] s_data,
   input  logic       s_valid,
   output logic       s_ready,
   output logic [7:0] m_data,
   output logic       m_valid,
   input  logic       m_ready,
   output logic       m_last,
   output logic       busy,
   output logic       frame_done
);
   localparam int CW = WIDTH > 1 ? $clog2(WIDTH) : 1;
   localparam int RW = HEIGHT > 1 ? $clog2(HEIGHT) : 1;
   localparam int PAD_I = (4 - (3 * WIDTH) % 4) % 4;
   localparam logic [1:0] PAD = 2'(PAD_I);
   localparam logic [1:0] PAD_LAST = 2'(PAD_I - 1);
   localparam logic [CW-1:0] LAST_COL = CW'(WIDTH - 1);
   localparam logic [RW-1:0] LAST_ROW = RW'(HEIGHT - 1);

   typedef enum logic [1:0] {IDLE, PIX, SKIP, DONE} state_t;

   state_t        state_q, state_d;
   logic [CW-1:0] col_q, col_d;
   logic [RW-1:0] row_q, row_d;
   logic [1:0]    phase_q, phase_d, pad_q, pad_d;
   logic [7:0]    b_q, b_d, g_q, g_d, m_data_q, m_data_d;
   logic          m_valid_q, m_valid_d, m_last_q, m_last_d;
   logic          load;
   logic [15:0]   luma;

   // weights sum to 256, so the 16-bit sum never overflows and the top byte is the gray value
   assign luma = 16'd77 * {8'd0, s_data} + 16'd150 * {8'd0, g_q} + 16'd29 * {8'd0, b_q};

   always_comb begin
      state_d = state_q;
      col_d = col_q;
      row_d = row_q;
      phase_d = phase_q;
      pad_d = pad_q;
      b_d = b_q;
      g_d = g_q;
      s_ready = 1'b0;
      frame_done = 1'b0;
      case (state_q)
         IDLE: if (start) begin
            state_d = PIX;
            col_d = '0;
            row_d = '0;
            phase_d = '0;
            pad_d = '0;
         end
         PIX: begin
            // only the R byte needs room in the output register; B and G flow in regardless
            s_ready = phase_q != 2'd2 || !m_valid_q || m_ready;
            if (s_valid && s_ready) begin
               phase_d = phase_q == 2'd2 ? 2'd0 : phase_q + 2'd1;
               b_d = phase_q == 2'd0 ? s_data : b_q;
               g_d = phase_q == 2'd1 ? s_data : g_q;
               if (phase_q == 2'd2) begin
                  if (col_q != LAST_COL) col_d = col_q + 1'b1;
                  else if (PAD != 2'd0) begin
                     state_d = SKIP;
                     pad_d = '0;
                  end else begin
                     col_d = '0;
                     row_d = row_q + 1'b1;
                     state_d = row_q == LAST_ROW ? DONE : PIX;
                  end
               end
            end
         end
         SKIP: begin
            s_ready = 1'b1;
            if (s_valid) begin
               pad_d = pad_q + 2'd1;
               if (pad_q == PAD_LAST) begin
                  col_d = '0;
                  row_d = row_q + 1'b1;
                  state_d = row_q == LAST_ROW ? DONE : PIX;
               end
            end
         end
         DONE: if (!m_valid_q || m_ready) begin
            frame_done = 1'b1;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
      load = state_q == PIX && phase_q == 2'd2 && s_valid && s_ready;
      m_valid_d = load || (m_valid_q && !m_ready);
      m_data_d = load ? luma[15:8] : m_data_q;
      m_last_d = load ? col_q == LAST_COL : m_last_q;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         col_q <= '0;
         row_q <= '0;
         phase_q <= '0;
         pad_q <= '0;
         b_q <= '0;
         g_q <= '0;
         m_data_q <= '0;
         m_valid_q <= 1'b0;
         m_last_q <= 1'b0;
      end else begin
         state_q <= state_d;
         col_q <= col_d;
         row_q <= row_d;
         phase_q <= phase_d;
         pad_q <= pad_d;
         b_q <= b_d;
         g_q <= g_d;
         m_data_q <= m_data_d;
         m_valid_q <= m_valid_d;
         m_last_q <= m_last_d;
      end
   end

   assign m_data = m_data_q;
   assign m_valid = m_valid_q;
   assign m_last = m_last_q;
   assign busy = state_q != IDLE;
endmodule

// File: tb/tb_gray_stream_ctrl.sv
// tb_gray_stream_ctrl: randomized frames on four geometries checked against a frame-level gray model
module tb_gray_stream_ctrl;
  localparam int NI = 4;
  localparam int WS [NI] = '{1, 2, 3, 4};
  localparam int HS [NI] = '{1, 2, 2, 1};
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start [NI];
  logic [7:0] s_data [NI];
  logic       s_valid [NI];
  logic       s_ready [NI];
  logic [7:0] m_data [NI];
  logic       m_valid [NI];
  logic       m_ready [NI];
  logic       m_last [NI];
  logic       busy [NI];
  logic       frame_done [NI];
  int         checks = 0;
  int         failures = 0;
  always #5 clk = ~clk;
  for (genvar k = 0; k < NI; k++) begin : g_dut
    gray_stream_ctrl #(.WIDTH(WS[k]), .HEIGHT(HS[k])) u_dut (
      .clk(clk), .rst_n(rst_n), .start(start[k]),
      .s_data(s_data[k]), .s_valid(s_valid[k]), .s_ready(s_ready[k]),
      .m_data(m_data[k]), .m_valid(m_valid[k]), .m_ready(m_ready[k]),
      .m_last(m_last[k]), .busy(busy[k]), .frame_done(frame_done[k])
    );
  end
  function automatic int pad_of(input int w);
    return (4 - (3 * w) % 4) % 4;
  endfunction
  task automatic make_frame(input int sel, input logic [7:0] padv, output logic [7:0] q[$]);
    int w = WS[sel];
    q = {};
    for (int r = 0; r < HS[sel]; r++) begin
      for (int i = 0; i < 3 * w; i++) q.push_back(8'($urandom_range(255)));
      for (int i = 0; i < pad_of(w); i++) q.push_back(padv);
    end
  endtask
  task automatic run_frame(input int sel, input logic [7:0] fb_in[$], input int mode, output logic [7:0] first_out);
    int w = WS[sel];
    int pad = pad_of(w);
    int rb = 3 * w + pad;
    int n = HS[sel] * rb;
    int idx = 0, got = 0, fd = 0, cyc = 0, first = -1, last_t = -1, pos, gv;
    logic exp_sr, hold_prev = 1'b0;
    logic [7:0] prev_d = 8'd0;
    logic [7:0] fb[$];
    logic [7:0] exp_d[$];
    logic exp_l[$];
    fb = fb_in;
    first_out = 8'd0;
    for (int r = 0; r < HS[sel]; r++)
      for (int c = 0; c < w; c++) begin
        pos = r * rb + 3 * c;
        gv = (77 * int'(fb[pos + 2]) + 150 * int'(fb[pos + 1]) + 29 * int'(fb[pos])) / 256;
        exp_d.push_back(8'(gv));
        exp_l.push_back(c == w - 1);
      end
    for (int i = 0; i < 3; i++) fb.push_back(8'h5A);
    @(negedge clk);
    start[sel] = 1'b1;
    @(negedge clk);
    start[sel] = 1'b0;
    checks++;
    if (busy[sel] !== 1'b1 || s_ready[sel] !== 1'b1) begin
      failures++;
      $display("FAIL start_resp: busy=%b s_ready=%b, wanted 1 1", busy[sel], s_ready[sel]);
    end
    while (fd == 0 && cyc < 2000) begin
      s_valid[sel] = (mode != 0 || $urandom_range(2) != 0) && idx < fb.size();
      s_data[sel] = idx < fb.size() ? fb[idx] : 8'd0;
      m_ready[sel] = mode == 1 ? 1'b1 : mode == 2 ? (first >= 0 && cyc - first >= 10) : ($urandom_range(2) != 0);
      start[sel] = mode == 1 && cyc == 4;
      #1;
      exp_sr = 1'b0;
      if (idx < n) begin
        pos = idx % rb;
        exp_sr = (pos < 3 * w && pos % 3 == 2) ? (!m_valid[sel] || m_ready[sel]) : 1'b1;
      end
      checks++;
      if (s_ready[sel] !== exp_sr) begin
        failures++;
        $display("FAIL s_ready: byte %0d cyc %0d got %b, wanted %b", idx, cyc, s_ready[sel], exp_sr);
      end
      if (hold_prev) begin
        checks++;
        if ({m_valid[sel], m_data[sel]} !== {1'b1, prev_d}) begin
          failures++;
          $display("FAIL hold: valid/data %b/%h, wanted 1/%h", m_valid[sel], m_data[sel], prev_d);
        end
      end
      hold_prev = m_valid[sel] && !m_ready[sel];
      prev_d = m_data[sel];
      if (m_valid[sel] && first < 0) first = cyc;
      if (m_valid[sel] && m_ready[sel]) begin
        checks++;
        if (got >= exp_d.size()) begin
          failures++;
          $display("FAIL extra_out: output %0d, only %0d wanted", got, exp_d.size());
        end else if (m_data[sel] !== exp_d[got] || m_last[sel] !== exp_l[got]) begin
          failures++;
          $display("FAIL pixel %0d: data/last %h/%b, wanted %h/%b", got, m_data[sel], m_last[sel], exp_d[got], exp_l[got]);
        end
        if (mode == 1 && last_t >= 0) begin
          checks++;
          if (cyc - last_t != (got % w == 0 ? 3 + pad : 3)) begin
            failures++;
            $display("FAIL spacing: output %0d gap %0d, wanted %0d", got, cyc - last_t, got % w == 0 ? 3 + pad : 3);
          end
        end
        if (got == 0) first_out = m_data[sel];
        last_t = cyc;
        got++;
      end
      if (s_valid[sel] && s_ready[sel]) idx++;
      if (frame_done[sel]) begin
        fd++;
        checks++;
        if (got != exp_d.size()) begin
          failures++;
          $display("FAIL done_early: %0d outputs at frame_done, wanted %0d", got, exp_d.size());
        end
      end
      checks++;
      if (busy[sel] !== 1'b1) begin
        failures++;
        $display("FAIL busy_frame: got %b, wanted 1", busy[sel]);
      end
      @(negedge clk);
      cyc++;
    end
    start[sel] = 1'b0;
    checks++;
    if (fd == 0) begin
      failures++;
      $display("FAIL timeout: no frame_done after %0d cycles, wanted 1 pulse", cyc);
    end
    checks++;
    if (busy[sel] !== 1'b0 || frame_done[sel] !== 1'b0 || s_ready[sel] !== 1'b0) begin
      failures++;
      $display("FAIL after_done: busy/frame_done/s_ready %b%b%b, wanted 000", busy[sel], frame_done[sel], s_ready[sel]);
    end
    checks++;
    if (idx != n) begin
      failures++;
      $display("FAIL consumed: %0d bytes, wanted %0d", idx, n);
    end
    s_valid[sel] = 1'b0;
    m_ready[sel] = 1'b0;
  endtask
  task automatic test_reset;
    repeat (2) @(negedge clk);
    for (int k = 0; k < NI; k++) begin
      checks++;
      if ({s_ready[k], m_valid[k], m_data[k], m_last[k], busy[k], frame_done[k]} !== 13'd0) begin
        failures++;
        $display("FAIL reset[%0d]: sr/mv/md/ml/busy/fd %b%b/%h/%b%b%b, wanted all 0", k,
                 s_ready[k], m_valid[k], m_data[k], m_last[k], busy[k], frame_done[k]);
      end
    end
    rst_n = 1'b1;
  endtask
  task automatic test_pixel_values;
    logic [31:0] tbl [5] = '{32'h0000FF4C, 32'h00FF0095, 32'hFF00001C, 32'hFFFFFFFF, 32'h00000000};
    logic [31:0] e;
    logic [7:0] q[$];
    logic [7:0] fo;
    for (int i = 0; i < 5; i++) begin
      e = tbl[i];
      q = {e[31:24], e[23:16], e[15:8], 8'hAA};
      run_frame(0, q, 0, fo);
      checks++;
      if (fo !== e[7:0]) begin
        failures++;
        $display("FAIL gray_const %0d: got %h, wanted %h", i, fo, e[7:0]);
      end
    end
    for (int i = 0; i < 3; i++) begin
      make_frame(0, 8'hAA, q);
      run_frame(0, q, 0, fo);
    end
  endtask
  task automatic test_padding;
    logic [7:0] q[$];
    logic [7:0] fo;
    for (int i = 0; i < 3; i++) begin
      make_frame(1, 8'hFF, q);
      run_frame(1, q, 0, fo);
    end
  endtask
  task automatic test_no_pad;
    logic [7:0] q[$];
    logic [7:0] fo;
    for (int i = 0; i < 2; i++) begin
      make_frame(3, 8'h00, q);
      run_frame(3, q, 0, fo);
    end
  endtask
  task automatic test_backpressure;
    logic [7:0] q[$];
    logic [7:0] fo;
    make_frame(1, 8'h00, q);
    run_frame(1, q, 2, fo);
  endtask
  task automatic test_full_rate;
    logic [7:0] q[$];
    logic [7:0] fo;
    make_frame(2, 8'h00, q);
    run_frame(2, q, 1, fo);
  endtask
  task automatic test_reset_mid;
    logic [7:0] q[$];
    logic [7:0] fo;
    int idx = 0;
    @(negedge clk);
    start[1] = 1'b1;
    @(negedge clk);
    start[1] = 1'b0;
    for (int c = 0; c < 50 && idx < 5; c++) begin
      s_valid[1] = 1'b1;
      s_data[1] = 8'($urandom_range(255));
      m_ready[1] = 1'b0;
      #1;
      if (s_ready[1]) idx++;
      @(negedge clk);
    end
    checks++;
    if (m_valid[1] !== 1'b1 || idx != 5) begin
      failures++;
      $display("FAIL pre_abort: m_valid %b after %0d bytes, wanted 1 after 5", m_valid[1], idx);
    end
    #2;
    rst_n = 1'b0;
    s_valid[1] = 1'b0;
    #1;
    checks++;
    if ({s_ready[1], m_valid[1], m_data[1], m_last[1], busy[1], frame_done[1]} !== 13'd0) begin
      failures++;
      $display("FAIL abort: sr/mv/md/ml/busy/fd %b%b/%h/%b%b%b, wanted all 0",
               s_ready[1], m_valid[1], m_data[1], m_last[1], busy[1], frame_done[1]);
    end
    @(negedge clk);
    rst_n = 1'b1;
    make_frame(1, 8'h3C, q);
    run_frame(1, q, 0, fo);
  endtask
  initial begin
    for (int k = 0; k < NI; k++) begin
      start[k] = 1'b0;
      s_valid[k] = 1'b0;
      s_data[k] = 8'd0;
      m_ready[k] = 1'b0;
    end
    test_reset();
    test_pixel_values();
    test_padding();
    test_no_pad();
    test_backpressure();
    test_full_rate();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
